// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader: FSM states,
// command header field positions, memory targets and address strides.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        HDR,
        ADDR,
        DATA_LO,
        DATA_HI,
        RUN
    } state_t;

    localparam int HDR_TGT_BIT = 31;
    localparam int HDR_GO_BIT  = 30;
    localparam int HDR_RSV_MSB = 29;
    localparam int HDR_RSV_LSB = 16;
    localparam int HDR_CNT_MSB = 15;
    localparam int HDR_CNT_LSB = 0;

    localparam logic TGT_IMEM = 1'b0;
    localparam logic TGT_DMEM = 1'b1;

    localparam logic [63:0] IMEM_STRIDE = 64'd4;
    localparam logic [63:0] DMEM_STRIDE = 64'd8;

endpackage

// File: rtl/prog_loader.sv
// Streams a header/address/payload command sequence into the CPU's instruction
// and data memory external ports, then hands control to the CPU on a GO header.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        halt,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    output logic        cpu_enable,
    output logic        busy,
    output logic        err
);

    state_t             state;
    logic   [CNT_W-1:0] cnt;
    logic   [63:0]      addr;
    logic   [31:0]      lo_hold;
    logic               tgt;
    logic               xfer;
    logic               last_word;

    // rst gates in_ready directly so no word is taken while reset is asserted.
    assign in_ready   = !rst && (state != RUN);
    assign xfer       = in_valid && in_ready;
    assign last_word  = (cnt == CNT_W'(1));
    assign busy       = (state == ADDR) || (state == DATA_LO) || (state == DATA_HI);
    assign cpu_enable = (state == RUN);
    assign ren_ext    = 1'b0;
    assign ren_ext_2  = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HDR;
            cnt         <= '0;
            addr        <= '0;
            lo_hold     <= '0;
            tgt         <= TGT_IMEM;
            err         <= 1'b0;
            wen_ext     <= 1'b0;
            addr_ext    <= '0;
            wdata_ext   <= '0;
            wen_ext_2   <= 1'b0;
            addr_ext_2  <= '0;
            wdata_ext_2 <= '0;
        end else begin
            wen_ext   <= 1'b0;
            wen_ext_2 <= 1'b0;
            case (state)
                HDR: begin
                    if (xfer) begin
                        if (|in_data[HDR_RSV_MSB:HDR_RSV_LSB]) begin
                            err <= 1'b1;
                        end else if (in_data[HDR_GO_BIT]) begin
                            state <= RUN;
                        end else begin
                            tgt   <= in_data[HDR_TGT_BIT];
                            cnt   <= CNT_W'(in_data[HDR_CNT_MSB:HDR_CNT_LSB]);
                            state <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (xfer) begin
                        addr  <= {32'd0, in_data};
                        state <= (cnt == '0) ? HDR : DATA_LO;
                    end
                end
                DATA_LO: begin
                    if (xfer) begin
                        if (tgt == TGT_IMEM) begin
                            wen_ext   <= 1'b1;
                            addr_ext  <= addr;
                            wdata_ext <= in_data;
                            addr      <= addr + IMEM_STRIDE;
                            cnt       <= cnt - CNT_W'(1);
                            if (last_word) state <= HDR;
                        end else begin
                            lo_hold <= in_data;
                            state   <= DATA_HI;
                        end
                    end
                end
                DATA_HI: begin
                    if (xfer) begin
                        wen_ext_2   <= 1'b1;
                        addr_ext_2  <= addr;
                        wdata_ext_2 <= {in_data, lo_hold};
                        addr        <= addr + DMEM_STRIDE;
                        cnt         <= cnt - CNT_W'(1);
                        state       <= last_word ? HDR : DATA_LO;
                    end
                end
                RUN: begin
                    if (halt) state <= HDR;
                end
                default: state <= HDR;
            endcase
        end
    end

endmodule
